// File: rtl/led_pwm_blinker_pkg.sv
// Shared constants and counter-sizing helper for the LED PWM/blink output stage.
package led_pwm_blinker_pkg;

  localparam int LED_COUNT    = 8;
  localparam int PWM_BITS_DEF = 4;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_blinker_if.sv
// Control/status bundle between the PIO registers and the LED output stage.
interface led_pwm_blinker_if
  import led_pwm_blinker_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) ();

  logic [LED_COUNT-1:0] led_in;
  logic [PWM_BITS-1:0]  duty;
  logic [LED_COUNT-1:0] blink_en;
  logic [LED_COUNT-1:0] led;
  logic                 update_pending;

  modport master (
    output led_in, duty, blink_en,
    input  led, update_pending
  );

  modport slave (
    input  led_in, duty, blink_en,
    output led, update_pending
  );

endinterface

// File: rtl/led_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, on the last count of each cycle.
module led_tick_gen
  import led_pwm_blinker_pkg::*;
#(
  parameter int TICK_DIV = 3125
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = cnt_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pwm_blinker.sv
// LED pin driver: PWM dimming and slow blinking, with all controls latched on PWM period boundaries.
module led_pwm_blinker
  import led_pwm_blinker_pkg::*;
#(
  parameter int TICK_DIV    = 3125,
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int BLINK_TICKS = 8000
) (
  input  logic               clk,
  input  logic               reset,
  led_pwm_blinker_if.slave   bus
);

  localparam int                  BW         = cnt_w(BLINK_TICKS);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;

  logic                 tick;
  logic                 period_end;
  logic                 pwm_on;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [PWM_BITS-1:0]  duty_act;
  logic [BW-1:0]        blink_cnt;
  logic                 blink_phase;
  logic [LED_COUNT-1:0] led_act;
  logic [LED_COUNT-1:0] blink_act;
  logic [LED_COUNT-1:0] led_nxt;
  logic                 pending_nxt;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Shadow copies only move at a period boundary so a period never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_act   <= '0;
      duty_act  <= '0;
      blink_act <= '0;
    end else if (period_end) begin
      led_act   <= bus.led_in;
      duty_act  <= bus.duty;
      blink_act <= bus.blink_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Full-scale duty is forced on; otherwise the last PWM slot would always be dark.
  always_comb begin
    period_end  = tick && (pwm_cnt == PWM_MAX);
    pwm_on      = (duty_act == PWM_MAX) || (pwm_cnt < duty_act);
    led_nxt     = led_act & {LED_COUNT{pwm_on}} & (~blink_act | {LED_COUNT{blink_phase}});
    pending_nxt = (bus.led_in != led_act) || (bus.duty != duty_act) ||
                  (bus.blink_en != blink_act);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.led            <= '0;
      bus.update_pending <= 1'b0;
    end else begin
      bus.led            <= led_nxt;
      bus.update_pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Directed bench for led_pwm_blinker with TICK_DIV=4, PWM_BITS=2, BLINK_TICKS=3 (16-clk period).
module tb_led_pwm_blinker;

  logic clk = 1'b0;
  logic reset;
  int   cyc;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cnt_a;
  int   cnt_b;

  always #5 clk = ~clk;

  led_pwm_blinker_if #(.PWM_BITS(2)) bus ();

  led_pwm_blinker #(
    .TICK_DIV    (4),
    .PWM_BITS    (2),
    .BLINK_TICKS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    cyc          = 0;
    reset        = 1'b1;
    bus.led_in   = 8'hFF;
    bus.duty     = 2'd3;
    bus.blink_en = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val("rst_led", bus.led, 8'h00);
      check_val("rst_pend", bus.update_pending, 1'b0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    cyc   = 0;

    // first boundary after reset
    run_to(1);
    check_val("pend_after_rel", bus.update_pending, 1'b1);
    run_to(15);
    check_val("led_pre_bound", bus.led, 8'h00);
    run_to(16);
    check_val("led_at_capture", bus.led, 8'h00);
    check_val("pend_at_capture", bus.update_pending, 1'b1);
    run_to(17);
    check_val("led_first_on", bus.led, 8'hFF);
    check_val("pend_cleared", bus.update_pending, 1'b0);
    run_to(25);
    check_val("led_steady", bus.led, 8'hFF);

    // duty=1: 4 of 16
    run_to(17);
    bus.duty     = 2'd1;
    bus.led_in   = 8'h01;
    bus.blink_en = 8'h00;
    run_to(32);
    check_val("led_old_period", bus.led, 8'hFF);
    cnt_a = 0;
    for (int i = 33; i <= 48; i++) begin
      step();
      if (bus.led == 8'h01) cnt_a++;
      if (cyc == 33) check_val("duty1_first", bus.led, 8'h01);
      if (cyc == 37) check_val("duty1_off", bus.led, 8'h00);
    end
    check_val("duty1_hi_cnt", cnt_a, 4);

    // duty=2: 8 of 16
    bus.duty = 2'd2;
    step();
    check_val("pend_duty2", bus.update_pending, 1'b1);
    run_to(64);
    cnt_a = 0;
    for (int i = 65; i <= 80; i++) begin
      step();
      if (bus.led == 8'h01) cnt_a++;
    end
    check_val("duty2_hi_cnt", cnt_a, 8);

    // duty=0: dark
    bus.duty = 2'd0;
    run_to(96);
    cnt_a = 0;
    for (int i = 97; i <= 112; i++) begin
      step();
      if (bus.led != 8'h00) cnt_a++;
    end
    check_val("duty0_on_cnt", cnt_a, 0);

    // blink on bits 0 and 2, full duty
    bus.duty     = 2'd3;
    bus.led_in   = 8'h0F;
    bus.blink_en = 8'h05;
    run_to(132);
    check_val("blink_vis", bus.led, 8'h0F);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 133; i <= 156; i++) begin
      step();
      if (bus.led[0]) cnt_a++;
      if ((bus.led & 8'h0A) == 8'h0A) cnt_b++;
      if (cyc == 133) check_val("blink_hide", bus.led, 8'h0A);
      if (cyc == 145) check_val("blink_show", bus.led, 8'h0F);
    end
    check_val("blink_bit0_hi", cnt_a, 12);
    check_val("blink_steady_bits", cnt_b, 24);
    run_to(157);
    check_val("blink_hide2", bus.led, 8'h0A);

    // mid-period change waits for boundary
    bus.led_in   = 8'h01;
    bus.blink_en = 8'h00;
    run_to(168);
    check_val("mid_led_before", bus.led, 8'h01);
    check_val("mid_pend_before", bus.update_pending, 1'b0);
    bus.led_in = 8'h80;
    step();
    check_val("mid_pend_rise", bus.update_pending, 1'b1);
    check_val("mid_led_hold", bus.led, 8'h01);
    run_to(176);
    check_val("mid_led_at_cap", bus.led, 8'h01);
    check_val("mid_pend_at_cap", bus.update_pending, 1'b1);
    run_to(177);
    check_val("mid_led_new", bus.led, 8'h80);
    check_val("mid_pend_fall", bus.update_pending, 1'b0);

    // short pulse inside one period is never captured
    bus.led_in = 8'h01;
    cnt_a = 0;
    for (int i = 178; i <= 240; i++) begin
      step();
      if (bus.led == 8'h03) cnt_a++;
      if (cyc == 178) check_val("pulse_pend_a", bus.update_pending, 1'b1);
      if (cyc == 193) check_val("pulse_led_base", bus.led, 8'h01);
      if (cyc == 194) bus.led_in = 8'h03;
      if (cyc == 195) check_val("pulse_pend_b", bus.update_pending, 1'b1);
      if (cyc == 198) bus.led_in = 8'h01;
      if (cyc == 199) check_val("pulse_pend_c", bus.update_pending, 1'b0);
      if (cyc == 210) check_val("pulse_led_keep", bus.led, 8'h01);
    end
    check_val("pulse_never_03", cnt_a, 0);

    // one-cycle reset mid-period
    run_to(248);
    check_val("rst2_led_before", bus.led, 8'h01);
    reset      = 1'b1;
    bus.led_in = 8'hF0;
    step();
    check_val("rst2_led", bus.led, 8'h00);
    check_val("rst2_pend", bus.update_pending, 1'b0);
    reset = 1'b0;
    cyc   = 0;
    run_to(1);
    check_val("rst2_pend_rise", bus.update_pending, 1'b1);
    run_to(8);
    check_val("rst2_led_mid", bus.led, 8'h00);
    run_to(16);
    check_val("rst2_led_cap", bus.led, 8'h00);
    run_to(17);
    check_val("rst2_led_new", bus.led, 8'hF0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
